button_debounce: RTL and testbench

//  Conditions one raw asynchronous pushbutton into clean, clock-synchronous events for the
//  4-bit up-counter stage downstream. It synchronises, debounces, and produces a stable level

---
 rtl/button_debounce_pkg.sv | 23 ++
 rtl/button_debounce_if.sv | 22 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/button_debounce.sv | 116 +++++++++++
 tb/tb_button_debounce.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/button_debounce_pkg.sv
// Shared constants for the pushbutton conditioning stage: FSM state
// encoding, the 50 MHz timing defaults used with the counter stage, and
// the counter-width helper.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    S_UP      = 2'd0,
    S_DN_PEND = 2'd1,
    S_DOWN    = 2'd2,
    S_UP_PEND = 2'd3
  } state_e;

  localparam int CLK_HZ                = 50_000_000;
  localparam int DEF_STABLE_CYCLES     = 1_000_000;   // 20 ms
  localparam int DEF_HOLD_CYCLES       = 25_000_000;  // 0.5 s
  localparam int DEF_REPEAT_CYCLES     = 5_000_000;   // 0.1 s

  // Counter width that can hold n-1, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Button-side signal bundle: raw button in, conditioned level/pulses out.
// master = button source (board/bench), slave = the debouncer.
interface button_debounce_if;
  logic btn_in;
  logic btn_level;
  logic btn_press;
  logic btn_release;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; both flops
// clear to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/button_debounce.sv
// Pushbutton conditioner: synchronise, debounce, and emit a stable level
// plus one-cycle press/release pulses, with optional auto-repeat of the
// press pulse while the button is held.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  button_debounce_if.slave   bus
);

  localparam int SW = cnt_width(STABLE_CYCLES);
  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int RW = cnt_width(REPEAT_CYCLES);

  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);
  localparam bit            REPEAT_EN = (HOLD_CYCLES > 0);

  logic          w_s;
  state_e        r_state;
  logic [SW-1:0] r_stab_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic [RW-1:0] r_rep_cnt;
  logic          r_level;
  logic          r_press;
  logic          r_release;

  sync_2ff u_sync (
    .clk (clk),
    .rst (reset),
    .i_d (bus.btn_in),
    .o_q (w_s)
  );

  // Debounce FSM with hold/repeat counters; all outputs registered here.
  // While hold_cnt ramps, rep_cnt is parked at its terminal value so the
  // first cycle after hold_cnt saturates fires the first repeat tick; the
  // counters are left untouched in UP_PEND so a release glitch resumes the
  // repeat cadence where it stopped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_UP;
      r_stab_cnt <= '0;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
      r_level    <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        S_UP: begin
          if (w_s) begin
            r_state    <= S_DN_PEND;
            r_stab_cnt <= SW'(1);
          end
        end
        S_DN_PEND: begin
          if (!w_s) begin
            r_state <= S_UP;
          end else if (r_stab_cnt == STAB_LAST) begin
            r_state    <= S_DOWN;
            r_level    <= 1'b1;
            r_press    <= 1'b1;
            r_hold_cnt <= '0;
            r_rep_cnt  <= REP_LAST;
          end else begin
            r_stab_cnt <= r_stab_cnt + 1'b1;
          end
        end
        S_DOWN: begin
          if (!w_s) begin
            r_state    <= S_UP_PEND;
            r_stab_cnt <= SW'(1);
          end else if (REPEAT_EN) begin
            if (r_hold_cnt != HOLD_LAST) begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
              r_rep_cnt  <= REP_LAST;
            end else if (r_rep_cnt == REP_LAST) begin
              r_press   <= 1'b1;
              r_rep_cnt <= '0;
            end else begin
              r_rep_cnt <= r_rep_cnt + 1'b1;
            end
          end
        end
        S_UP_PEND: begin
          if (w_s) begin
            r_state <= S_DOWN;
          end else if (r_stab_cnt == STAB_LAST) begin
            r_state   <= S_UP;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_stab_cnt <= r_stab_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_UP;
        end
      endcase
    end
  end

  assign bus.btn_level   = r_level;
  assign bus.btn_press   = r_press;
  assign bus.btn_release = r_release;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce (STABLE=4, HOLD=10, REPEAT=3).
// Stimulus pushes expected pulses (kind + clock-edge index) into a queue;
// a negedge monitor pops and compares every pulse the DUT produces.
module tb_button_debounce;

  localparam int STABLE = 4;
  localparam int HOLD   = 10;
  localparam int REPEAT = 3;

  typedef struct {
    bit is_press;
    int cyc;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_err    = 0;
  ev_t  exp_q[$];
  ev_t  mon_ev;

  button_debounce_if bus_if ();

  button_debounce #(
    .STABLE_CYCLES (STABLE),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REPEAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Index of the most recent rising clock edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input bit p, input int c);
    exp_q.push_back('{is_press: p, cyc: c});
  endtask

  task automatic at_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Scoreboard monitor: every pulse must match the next expected event.
  always @(negedge clk) begin
    if (bus_if.btn_press || bus_if.btn_release) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_pulse: cyc %0d press=%0d release=%0d, no pulse expected",
                 cyc, bus_if.btn_press, bus_if.btn_release);
      end else begin
        mon_ev = exp_q.pop_front();
        chk("pulse_kind", int'(bus_if.btn_press), int'(mon_ev.is_press));
        chk("pulse_cycle", cyc, mon_ev.cyc);
        chk("level_at_pulse", int'(bus_if.btn_level), int'(mon_ev.is_press));
        chk("press_release_excl", int'(bus_if.btn_press & bus_if.btn_release), 0);
      end
    end
  end

  initial begin
    int c;
    logic [5:0] bpat;

    // 1. Reset held with button pressed, then released.
    bus_if.btn_in = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("rst_level", int'(bus_if.btn_level), 0);
    chk("rst_press", int'(bus_if.btn_press), 0);
    chk("rst_release", int'(bus_if.btn_release), 0);
    repeat (3) @(negedge clk);
    chk("rst_hold_level", int'(bus_if.btn_level), 0);
    chk("rst_hold_press", int'(bus_if.btn_press), 0);
    c = cyc;
    reset = 1'b0;
    expect_ev(1'b1, c + 6);
    at_cyc(c + 6);
    chk("t1_level_hi", int'(bus_if.btn_level), 1);
    bus_if.btn_in = 1'b0;
    expect_ev(1'b0, c + 12);
    at_cyc(c + 16);
    chk("t1_level_lo", int'(bus_if.btn_level), 0);

    // 2. Clean press held 8 cycles, clean release, no repeat.
    c = cyc;
    bus_if.btn_in = 1'b1;
    expect_ev(1'b1, c + 6);
    at_cyc(c + 7);
    chk("t2_level_hi", int'(bus_if.btn_level), 1);
    at_cyc(c + 8);
    bus_if.btn_in = 1'b0;
    expect_ev(1'b0, c + 14);
    at_cyc(c + 18);
    chk("t2_level_lo", int'(bus_if.btn_level), 0);

    // 3. Bouncing press 1,0,1,1,0,1 then steady 1.
    c = cyc;
    bpat = 6'b101101;
    for (int i = 0; i < 6; i++) begin
      at_cyc(c + i);
      bus_if.btn_in = bpat[i];
    end
    expect_ev(1'b1, c + 11);
    at_cyc(c + 10);
    chk("t3_level_pend", int'(bus_if.btn_level), 0);
    at_cyc(c + 12);
    bus_if.btn_in = 1'b0;
    expect_ev(1'b0, c + 18);
    at_cyc(c + 22);

    // 4. Hold 30 cycles: press, repeat at +10, then every 3, none in UP_PEND.
    c = cyc;
    bus_if.btn_in = 1'b1;
    expect_ev(1'b1, c + 6);
    expect_ev(1'b1, c + 16);
    expect_ev(1'b1, c + 19);
    expect_ev(1'b1, c + 22);
    expect_ev(1'b1, c + 25);
    expect_ev(1'b1, c + 28);
    expect_ev(1'b1, c + 31);
    at_cyc(c + 30);
    bus_if.btn_in = 1'b0;
    expect_ev(1'b0, c + 36);
    at_cyc(c + 34);
    chk("t4_level_uppend", int'(bus_if.btn_level), 1);
    at_cyc(c + 40);
    chk("t4_level_lo", int'(bus_if.btn_level), 0);

    // 5. Two-cycle release glitch while held; repeat resumes from frozen count.
    c = cyc;
    bus_if.btn_in = 1'b1;
    expect_ev(1'b1, c + 6);
    at_cyc(c + 10);
    bus_if.btn_in = 1'b0;
    at_cyc(c + 12);
    bus_if.btn_in = 1'b1;
    expect_ev(1'b1, c + 19);
    expect_ev(1'b1, c + 22);
    at_cyc(c + 14);
    chk("t5_level_glitch", int'(bus_if.btn_level), 1);
    at_cyc(c + 20);
    bus_if.btn_in = 1'b0;
    expect_ev(1'b0, c + 26);
    at_cyc(c + 30);
    chk("t5_level_lo", int'(bus_if.btn_level), 0);

    // 6a. Reset during DN_PEND: no pulse afterwards.
    c = cyc;
    bus_if.btn_in = 1'b1;
    at_cyc(c + 4);
    reset = 1'b1;
    bus_if.btn_in = 1'b0;
    #1;
    chk("t6a_press", int'(bus_if.btn_press), 0);
    chk("t6a_level", int'(bus_if.btn_level), 0);
    at_cyc(c + 7);
    reset = 1'b0;
    at_cyc(c + 17);
    chk("t6a_level_after", int'(bus_if.btn_level), 0);

    // 6b. Reset mid-repeat: level drops at once, no further pulses.
    c = cyc;
    bus_if.btn_in = 1'b1;
    expect_ev(1'b1, c + 6);
    expect_ev(1'b1, c + 16);
    expect_ev(1'b1, c + 19);
    at_cyc(c + 20);
    chk("t6b_level_before", int'(bus_if.btn_level), 1);
    reset = 1'b1;
    bus_if.btn_in = 1'b0;
    #1;
    chk("t6b_level_async", int'(bus_if.btn_level), 0);
    chk("t6b_press_async", int'(bus_if.btn_press), 0);
    chk("t6b_release_async", int'(bus_if.btn_release), 0);
    at_cyc(c + 23);
    reset = 1'b0;
    at_cyc(c + 33);
    chk("t6b_level_after", int'(bus_if.btn_level), 0);

    // Clean press after reset: confirms the FSM restarted in UP.
    c = cyc;
    bus_if.btn_in = 1'b1;
    expect_ev(1'b1, c + 6);
    at_cyc(c + 8);
    bus_if.btn_in = 1'b0;
    expect_ev(1'b0, c + 14);
    at_cyc(c + 20);
    chk("final_level", int'(bus_if.btn_level), 0);
    chk("pending_events", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
